// File: rtl/qracc_bus_bridge.sv
// Host-to-accelerator bus bridge: queues host requests in a FIFO and issues them
// one at a time on the accelerator bus, returning read data (or a timeout error) in order.
module qracc_bus_bridge #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                              clk,
  input  logic                              nrst,
  input  logic                              host_valid,
  output logic                              host_ready,
  input  logic                              host_wen,
  input  logic [31:0]                       host_addr,
  input  logic [31:0]                       host_wdata,
  output logic                              rsp_valid,
  output logic [31:0]                       rsp_data,
  output logic                              rsp_err,
  input  logic                              rsp_ready,
  output logic                              bus_valid,
  input  logic                              bus_ready,
  output logic                              bus_wen,
  output logic [31:0]                       bus_addr,
  output logic [31:0]                       bus_data_in,
  input  logic [31:0]                       bus_data_out,
  input  logic                              bus_rd_data_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned EW = 65;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic            host_ready_q, host_ready_d;
  logic            bus_valid_q, bus_valid_d;
  logic            bus_wen_q, bus_wen_d;
  logic [31:0]     bus_addr_q, bus_addr_d;
  logic [31:0]     bus_data_q, bus_data_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic            busy_q, busy_d;
  logic            push, pop;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic [EW-1:0]   head;

  assign push = host_valid && host_ready_q;
  assign head = mem_q[rptr_q];

  // Request storage; entries need no reset since count/pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {host_wen, host_addr, host_wdata};
  end

  // Next-state, FIFO bookkeeping and registered output values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bus_wen_d  = bus_wen_q;
    bus_addr_d = bus_addr_q;
    bus_data_d = bus_data_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    pop        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d    = ISSUE;
          bus_wen_d  = head[64];
          bus_addr_d = head[63:32];
          bus_data_d = head[31:0];
        end
      end
      ISSUE: begin
        if (bus_ready) begin
          pop     = 1'b1;
          state_d = bus_wen_q ? IDLE : WAIT_RD;
          cnt_d   = '0;
        end
      end
      WAIT_RD: begin
        // Real data takes priority over a coincident timeout.
        if (bus_rd_data_valid) begin
          rsp_data_d = bus_data_out;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          rsp_data_d = ERR_DATA;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    wptr_d = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    host_ready_d = (count_d < CW'(FIFO_DEPTH));
    bus_valid_d  = (state_d == ISSUE);
    rsp_valid_d  = (state_d == RESP);
    busy_d       = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      cnt_q        <= '0;
      host_ready_q <= 1'b0;
      bus_valid_q  <= 1'b0;
      bus_wen_q    <= 1'b0;
      bus_addr_q   <= '0;
      bus_data_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      cnt_q        <= cnt_d;
      host_ready_q <= host_ready_d;
      bus_valid_q  <= bus_valid_d;
      bus_wen_q    <= bus_wen_d;
      bus_addr_q   <= bus_addr_d;
      bus_data_q   <= bus_data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign host_ready  = host_ready_q;
  assign bus_valid   = bus_valid_q;
  assign bus_wen     = bus_wen_q;
  assign bus_addr    = bus_addr_q;
  assign bus_data_in = bus_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign fifo_count  = count_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_qracc_bus_bridge.sv
// Directed self-checking bench for qracc_bus_bridge: one task per scenario.
module tb_qracc_bus_bridge;

  logic        clk = 1'b0;
  logic        nrst;
  logic        host_valid, host_ready, host_wen;
  logic [31:0] host_addr, host_wdata;
  logic        rsp_valid, rsp_err, rsp_ready;
  logic [31:0] rsp_data;
  logic        bus_valid, bus_ready, bus_wen, bus_rd_data_valid;
  logic [31:0] bus_addr, bus_data_in, bus_data_out;
  logic [2:0]  fifo_count;
  logic        busy;

  int total = 0;
  int bad   = 0;

  qracc_bus_bridge #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(64), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .nrst(nrst),
    .host_valid(host_valid), .host_ready(host_ready), .host_wen(host_wen),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_wen(bus_wen), .bus_addr(bus_addr),
    .bus_data_in(bus_data_in), .bus_data_out(bus_data_out),
    .bus_rd_data_valid(bus_rd_data_valid),
    .fifo_count(fifo_count), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic wen, input logic [31:0] addr, input logic [31:0] data);
    host_valid = 1'b1;
    host_wen   = wen;
    host_addr  = addr;
    host_wdata = data;
    tick();
    host_valid = 1'b0;
  endtask

  task automatic wait_bus(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (bus_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [134:0] outs;
    nrst = 1'b0;
    repeat (3) tick();
    outs = {bus_valid, bus_wen, bus_addr, bus_data_in, rsp_valid, rsp_err, rsp_data,
            busy, host_ready, fifo_count};
    total++;
    if (outs !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", outs);
    end
    nrst = 1'b1;
    tick();
    total++;
    if (host_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: host_ready=%b busy=%b want 1 0", host_ready, busy);
    end
  endtask

  task automatic test_write_read();
    bit ok;
    bus_ready = 1'b1;
    push(1'b1, 32'h10, 32'hA5);
    push(1'b0, 32'h10, 32'h0);
    wait_bus(10, ok);
    total++;
    if (!ok || bus_wen !== 1'b1 || bus_addr !== 32'h10 || bus_data_in !== 32'hA5) begin
      bad++;
      $display("FAIL wr_first: ok=%b wen=%b addr=%h data=%h want 1 1 10 a5", ok, bus_wen, bus_addr, bus_data_in);
    end
    tick();
    total++;
    if (bus_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_gap: bus_valid=%b want 0", bus_valid);
    end
    wait_bus(10, ok);
    total++;
    if (!ok || bus_wen !== 1'b0 || bus_addr !== 32'h10) begin
      bad++;
      $display("FAIL rd_second: ok=%b wen=%b addr=%h want 1 0 10", ok, bus_wen, bus_addr);
    end
    tick();
    tick();
    bus_rd_data_valid = 1'b1;
    bus_data_out      = 32'hA5;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rsp_early: rsp_valid=%b want 0", rsp_valid);
    end
    tick();
    bus_rd_data_valid = 1'b0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'hA5 || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL rd_rsp: valid=%b data=%h err=%b want 1 a5 0", rsp_valid, rsp_data, rsp_err);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b0) ok = 1'b0;
      tick();
    end
    total++;
    if (!ok || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_rsp: extra rsp=%b busy=%b want 1 0", ok, busy);
    end
  endtask

  task automatic test_fifo_full();
    int acc;
    int n;
    bus_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      host_valid = 1'b1;
      host_wen   = 1'b1;
      host_addr  = 32'h100 + 32'(i);
      host_wdata = 32'h1000 + 32'(i);
      if (host_ready === 1'b1) acc++;
      tick();
    end
    host_valid = 1'b0;
    total++;
    if (acc != 4 || host_ready !== 1'b0 || fifo_count !== 3'd4) begin
      bad++;
      $display("FAIL fifo_full: acc=%0d ready=%b count=%0d want 4 0 4", acc, host_ready, fifo_count);
    end
    bus_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      if (bus_valid === 1'b1) begin
        total++;
        if (bus_addr !== 32'h100 + 32'(n) || bus_data_in !== 32'h1000 + 32'(n) || bus_wen !== 1'b1) begin
          bad++;
          $display("FAIL order_%0d: addr=%h data=%h want %h %h", n, bus_addr, bus_data_in,
                   32'h100 + 32'(n), 32'h1000 + 32'(n));
        end
        n++;
      end
      tick();
    end
    total++;
    if (n != 4 || fifo_count !== 3'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL drain: txns=%0d count=%0d busy=%b want 4 0 0", n, fifo_count, busy);
    end
  endtask

  task automatic test_timeout(input bit race);
    bit ok;
    bus_ready = 1'b1;
    push(1'b0, 32'h20, 32'h0);
    wait_bus(10, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL to_issue: bus_valid never seen");
    end
    tick();
    repeat (63) tick();
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL to_early: rsp_valid=%b after 63 cycles want 0", rsp_valid);
    end
    if (race) begin
      bus_rd_data_valid = 1'b1;
      bus_data_out      = 32'h5A;
    end
    tick();
    bus_rd_data_valid = 1'b0;
    total++;
    if (race) begin
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h5A || rsp_err !== 1'b0) begin
        bad++;
        $display("FAIL to_race: valid=%b data=%h err=%b want 1 5a 0", rsp_valid, rsp_data, rsp_err);
      end
    end else begin
      if (rsp_valid !== 1'b1 || rsp_data !== 32'hDEAD_BEEF || rsp_err !== 1'b1) begin
        bad++;
        $display("FAIL to_err: valid=%b data=%h err=%b want 1 deadbeef 1", rsp_valid, rsp_data, rsp_err);
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit held;
    bus_ready = 1'b1;
    rsp_ready = 1'b0;
    push(1'b0, 32'h30, 32'h0);
    push(1'b0, 32'h34, 32'h0);
    wait_bus(10, ok);
    total++;
    if (!ok || bus_addr !== 32'h30) begin
      bad++;
      $display("FAIL bp_first: ok=%b addr=%h want 1 30", ok, bus_addr);
    end
    tick();
    tick();
    bus_rd_data_valid = 1'b1;
    bus_data_out      = 32'h1111;
    tick();
    bus_rd_data_valid = 1'b0;
    held = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h1111 || rsp_err !== 1'b0 || bus_valid !== 1'b0) held = 1'b0;
      tick();
    end
    total++;
    if (!held || fifo_count !== 3'd1) begin
      bad++;
      $display("FAIL bp_hold: stable=%b count=%0d want 1 1", held, fifo_count);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    wait_bus(10, ok);
    total++;
    if (!ok || bus_addr !== 32'h34 || bus_wen !== 1'b0) begin
      bad++;
      $display("FAIL bp_second: ok=%b addr=%h wen=%b want 1 34 0", ok, bus_addr, bus_wen);
    end
    tick();
    bus_rd_data_valid = 1'b1;
    bus_data_out      = 32'h2222;
    tick();
    bus_rd_data_valid = 1'b0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h2222) begin
      bad++;
      $display("FAIL bp_rsp2: valid=%b data=%h want 1 2222", rsp_valid, rsp_data);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit quiet;
    logic [134:0] outs;
    bus_ready = 1'b1;
    push(1'b0, 32'h40, 32'h0);
    push(1'b1, 32'h44, 32'h99);
    wait_bus(10, ok);
    tick();
    tick();
    nrst = 1'b0;
    #1;
    outs = {bus_valid, bus_wen, bus_addr, bus_data_in, rsp_valid, rsp_err, rsp_data,
            busy, host_ready, fifo_count};
    total++;
    if (!ok || outs !== '0) begin
      bad++;
      $display("FAIL mid_reset: ok=%b outs=%h want 1 0", ok, outs);
    end
    tick();
    tick();
    nrst = 1'b1;
    tick();
    tick();
    bus_rd_data_valid = 1'b1;
    bus_data_out      = 32'h77;
    tick();
    bus_rd_data_valid = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid !== 1'b0 || bus_valid !== 1'b0 || fifo_count !== 3'd0) quiet = 1'b0;
      tick();
    end
    total++;
    if (!quiet || busy !== 1'b0) begin
      bad++;
      $display("FAIL post_reset: quiet=%b busy=%b want 1 0", quiet, busy);
    end
  endtask

  initial begin
    nrst              = 1'b0;
    host_valid        = 1'b0;
    host_wen          = 1'b0;
    host_addr         = '0;
    host_wdata        = '0;
    rsp_ready         = 1'b0;
    bus_ready         = 1'b0;
    bus_data_out      = '0;
    bus_rd_data_valid = 1'b0;
    test_reset();
    test_write_read();
    test_fifo_full();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qracc_bus_bridge.md
QRACC_BUS_BRIDGE -- requirements
Module: qracc_bus_bridge

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, 4, request FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, 64, maximum WAIT_RD cycles before a read is failed.
REQ-003 SHALL have parameter ERR_DATA, 32'hDEAD_BEEF, data returned on read timeout.
REQ-004 SHALL use a single clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk  input  1  clock, rising edge.
REQ-006 SHALL have port nrst  input  1  asynchronous active-low reset.
REQ-007 SHALL have host request ports:
- host_valid  input  1  request valid.
- host_ready  output  1  request accepted.
- host_wen  input  1  1=write, 0=read.
- host_addr  input  32  address.
- host_wdata  input  32  write data.
REQ-008 SHALL have host response ports:
- rsp_valid  output  1  read response valid.
- rsp_data  output  32  read data.
- rsp_err  output  1  response is a timeout error.
- rsp_ready  input  1  response consumed.
REQ-009 SHALL have accelerator bus ports:
- bus_valid  output  1  transaction valid.
- bus_ready  input  1  transaction accepted.
- bus_wen  output  1  write enable.
- bus_addr  output  32  address.
- bus_data_in  output  32  write data to accelerator.
- bus_data_out  input  32  read data from accelerator.
- bus_rd_data_valid  input  1  read data strobe.
REQ-010 SHALL have status ports:
- fifo_count  output  $clog2(FIFO_DEPTH+1)  queued requests.
- busy  output  1  high when state!=IDLE or fifo_count!=0.

Function
REQ-011 SHALL buffer requests {wen,addr,wdata} in a FIFO; push on host_valid&&host_ready; host_ready = (fifo_count<FIFO_DEPTH), from the registered count, with no same-cycle pop bypass.
REQ-012 SHALL wrap read/write pointers modulo FIFO_DEPTH; simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT_RD, RESP.
REQ-014 IDLE: fifo_count!=0 -> ISSUE on next edge.
REQ-015 ISSUE behaviour:
- bus_valid=1; bus_wen/bus_addr/bus_data_in driven from the FIFO head and held stable until bus_ready.
- On bus_valid&&bus_ready: pop the head.
- Write -> IDLE; read -> WAIT_RD with the timeout counter cleared.
REQ-016 WAIT_RD behaviour:
- bus_rd_data_valid=1 -> capture bus_data_out into rsp_data, rsp_err=0, -> RESP.
- Otherwise increment the counter; at the TIMEOUT_CYCLES-th cycle without data: rsp_data=ERR_DATA, rsp_err=1, -> RESP.
REQ-017 If bus_rd_data_valid coincides with timeout expiry, real data SHALL win (rsp_err=0).
REQ-018 RESP: rsp_valid=1 with rsp_data/rsp_err stable; on rsp_ready -> IDLE; no bus transaction issued in RESP.
REQ-019 Single outstanding transaction: read responses SHALL return in request order; writes SHALL produce no response.
REQ-020 bus_rd_data_valid outside WAIT_RD SHALL be ignored.
REQ-021 Minimum spacing SHALL be one IDLE cycle between consecutive bus transactions; the latency from a read's bus handshake to rsp_valid is (rd_data_valid cycle + 1).
REQ-022 bus_valid SHALL be 0 in every state except ISSUE.

Reset
REQ-023 While nrst=0 the following SHALL hold:
- State=IDLE, FIFO empty, fifo_count=0, counter=0.
- bus_valid, bus_wen, rsp_valid, rsp_err, busy = 0; bus_addr, bus_data_in, rsp_data = 0.
- host_ready forced to 0.
REQ-024 Reset mid-operation SHALL discard queued and in-flight requests; no response SHALL be produced for them after release.

Verification
REQ-025 Write 0x10<-0xA5 then read 0x10, bus_ready=1, rd_data_valid with 0xA5 two cycles after the read handshake -> exactly one rsp_valid with rsp_data=0xA5, rsp_err=0; bus sees the write first.
REQ-026 bus_ready=0, five back-to-back host pushes -> four accepted, host_ready=0, fifo_count=4; then bus_ready=1 -> four transactions in push order, fifo_count returns to 0.
REQ-027 Read with bus_rd_data_valid never asserted -> after 64 WAIT_RD cycles: rsp_valid=1, rsp_data=0xDEAD_BEEF, rsp_err=1.
REQ-028 rsp_ready=0 for 10 cycles with a second read queued -> rsp_valid/rsp_data held stable, bus_valid=0 throughout; second read issues only after rsp_ready.
REQ-029 nrst pulsed low during WAIT_RD, late bus_rd_data_valid after release -> all outputs 0 during reset, no rsp_valid afterwards, fifo_count=0.
REQ-030 bus_rd_data_valid=1 with 0x5A exactly on the timeout cycle -> rsp_data=0x5A, rsp_err=0.
